// File: rtl/mem_arbiter_if.sv
// Bundle of the two cache request/response ports and the external memory bus.
// The arbiter uses the master view; the caches and memory side use the slave view.
interface mem_arbiter_if #(
  parameter int BLOCKSZ     = 512,
  parameter int BEATW       = 64,
  parameter int ADDRESSSIZE = 64
);
  logic                   c0_req;
  logic                   c1_req;
  logic                   c0_wr_en;
  logic                   c1_wr_en;
  logic [ADDRESSSIZE-1:0] c0_addr;
  logic [ADDRESSSIZE-1:0] c1_addr;
  logic [BLOCKSZ-1:0]     c0_wdata;
  logic [BLOCKSZ-1:0]     c1_wdata;
  logic [BLOCKSZ-1:0]     c0_rdata;
  logic [BLOCKSZ-1:0]     c1_rdata;
  logic                   c0_valid;
  logic                   c1_valid;

  logic                   m_req;
  logic                   m_wr;
  logic [ADDRESSSIZE-1:0] m_addr;
  logic                   m_grant;
  logic [BEATW-1:0]       m_wdata;
  logic                   m_wvalid;
  logic [BEATW-1:0]       m_rdata;
  logic                   m_rvalid;

  modport master (
    input  c0_req, c1_req, c0_wr_en, c1_wr_en, c0_addr, c1_addr, c0_wdata, c1_wdata,
    input  m_grant, m_rdata, m_rvalid,
    output c0_rdata, c1_rdata, c0_valid, c1_valid,
    output m_req, m_wr, m_addr, m_wdata, m_wvalid
  );

  modport slave (
    output c0_req, c1_req, c0_wr_en, c1_wr_en, c0_addr, c1_addr, c0_wdata, c1_wdata,
    output m_grant, m_rdata, m_rvalid,
    input  c0_rdata, c1_rdata, c0_valid, c1_valid,
    input  m_req, m_wr, m_addr, m_wdata, m_wvalid
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port line arbiter running 8-beat bursts on a shared 64-bit memory bus.
// Define MEM_ARBITER_FIXED_PRIO_EN for fixed priority (port 1 wins ties); default is round-robin.
module mem_arbiter #(
  parameter int BLOCKSZ     = 512,
  parameter int BEATW       = 64,
  parameter int ADDRESSSIZE = 64
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.master bus
);
  localparam int BEATS = BLOCKSZ / BEATW;
  localparam int BW    = $clog2(BEATS);
  localparam logic [ADDRESSSIZE-1:0] ALIGN_MASK = ~ADDRESSSIZE'(BLOCKSZ / 8 - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, ADDR, WBEATS, RBEATS, RESP} state_e;

  state_e                 state_q;
  logic [BW-1:0]          beat_q;
  logic [1:0]             pend_q;
  logic [1:0]             wr_q;
  logic [ADDRESSSIZE-1:0] addr_q  [2];
  logic [BLOCKSZ-1:0]     wdata_q [2];
  logic [BLOCKSZ-1:0]     line_q;
  logic                   win_q;
  logic                   last_q;
  logic                   m_req_q;
  logic                   m_wr_q;
  logic                   m_wvalid_q;
  logic [ADDRESSSIZE-1:0] m_addr_q;
  logic [BEATW-1:0]       m_wdata_q;
  logic [1:0]             valid_q;
  logic [BLOCKSZ-1:0]     rdata_q [2];

  logic [1:0]             req_in;
  logic [1:0]             wr_in;
  logic [ADDRESSSIZE-1:0] addr_in  [2];
  logic [BLOCKSZ-1:0]     wdata_in [2];
  logic [1:0]             busy;
  logic [1:0]             take;
  logic                   win_d;
  logic [BLOCKSZ-1:0]     line_d;

  // A port in service (any non-IDLE state) cannot re-arm its pending latch.
  always_comb begin
    req_in      = {bus.c1_req, bus.c0_req};
    wr_in       = {bus.c1_wr_en, bus.c0_wr_en};
    addr_in[0]  = bus.c0_addr & ALIGN_MASK;
    addr_in[1]  = bus.c1_addr & ALIGN_MASK;
    wdata_in[0] = bus.c0_wdata;
    wdata_in[1] = bus.c1_wdata;
    busy        = 2'b00;
    if (state_q != IDLE) busy[win_q] = 1'b1;
    take        = req_in & ~pend_q & ~busy;
    win_d       = pend_q[1];
    if (pend_q == 2'b11) begin
`ifdef MEM_ARBITER_FIXED_PRIO_EN
      win_d = 1'b1;
`else
      win_d = ~last_q;
`endif
    end
    line_d = line_q;
    line_d[int'(beat_q) * BEATW +: BEATW] = bus.m_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      pend_q     <= '0;
      wr_q       <= '0;
      addr_q[0]  <= '0;
      addr_q[1]  <= '0;
      wdata_q[0] <= '0;
      wdata_q[1] <= '0;
      line_q     <= '0;
      win_q      <= 1'b0;
      last_q     <= 1'b1;
      m_req_q    <= 1'b0;
      m_wr_q     <= 1'b0;
      m_wvalid_q <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      valid_q    <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (take[n]) begin
          pend_q[n]  <= 1'b1;
          wr_q[n]    <= wr_in[n];
          addr_q[n]  <= addr_in[n];
          wdata_q[n] <= wdata_in[n];
        end
      end

      unique case (state_q)
        IDLE: begin
          if (|pend_q) begin
            win_q    <= win_d;
            m_req_q  <= 1'b1;
            m_wr_q   <= wr_q[win_d];
            m_addr_q <= addr_q[win_d];
            line_q   <= wdata_q[win_d];
            state_q  <= ADDR;
          end
        end
        ADDR: begin
          if (bus.m_grant) begin
            m_req_q <= 1'b0;
            beat_q  <= '0;
            if (m_wr_q) begin
              m_wvalid_q <= 1'b1;
              m_wdata_q  <= line_q[BEATW-1:0];
              state_q    <= WBEATS;
            end else begin
              state_q <= RBEATS;
            end
          end
        end
        // The completion pulse is raised on the edge leaving the last beat so it lands in RESP.
        WBEATS: begin
          if (beat_q == LAST_BEAT) begin
            m_wvalid_q     <= 1'b0;
            beat_q         <= '0;
            valid_q[win_q] <= 1'b1;
            state_q        <= RESP;
          end else begin
            beat_q    <= beat_q + 1'b1;
            m_wdata_q <= line_q[(int'(beat_q) + 1) * BEATW +: BEATW];
          end
        end
        RBEATS: begin
          if (bus.m_rvalid) begin
            line_q <= line_d;
            if (beat_q == LAST_BEAT) begin
              beat_q         <= '0;
              valid_q[win_q] <= 1'b1;
              rdata_q[win_q] <= line_d;
              state_q        <= RESP;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        RESP: begin
          valid_q       <= '0;
          pend_q[win_q] <= 1'b0;
          last_q        <= win_q;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.m_req    = m_req_q;
  assign bus.m_wr     = m_wr_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;
  assign bus.m_wvalid = m_wvalid_q;
  assign bus.c0_valid = valid_q[0];
  assign bus.c1_valid = valid_q[1];
  assign bus.c0_rdata = rdata_q[0];
  assign bus.c1_rdata = rdata_q[1];
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scenario tasks drive caches and a bus model,
// completions are matched against a queue of expected results.
module tb_mem_arbiter;
  localparam int BLOCKSZ     = 512;
  localparam int BEATW       = 64;
  localparam int ADDRESSSIZE = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.BLOCKSZ(BLOCKSZ), .BEATW(BEATW), .ADDRESSSIZE(ADDRESSSIZE)) bus ();

  mem_arbiter #(.BLOCKSZ(BLOCKSZ), .BEATW(BEATW), .ADDRESSSIZE(ADDRESSSIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int                     port;
    bit                     rd;
    logic [ADDRESSSIZE-1:0] addr;
    logic [BLOCKSZ-1:0]     line;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   v0_total = 0;
  int   v1_total = 0;

  bit                     obs_timeout;
  bit                     obs_stable;
  bit                     obs_early_wv;
  bit                     obs_consec;
  int                     obs_reqlat;
  int                     obs_nbeats;
  int                     obs_vport;
  int                     obs_vlat;
  int                     obs_vlen;
  logic                   obs_wr;
  logic [ADDRESSSIZE-1:0] obs_addr;
  logic [BLOCKSZ-1:0]     obs_rdata;
  logic [BEATW-1:0]       obs_beats [8];

  function automatic logic [BLOCKSZ-1:0] mk_line(input logic [63:0] base);
    logic [BLOCKSZ-1:0] l;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = base + 64'(k);
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.c0_valid === 1'b1) v0_total++;
    if (bus.c1_valid === 1'b1) v1_total++;
  endtask

  task automatic set_req(input int port, input bit wr, input logic [63:0] addr,
                         input logic [BLOCKSZ-1:0] wdata);
    if (port == 0) begin
      bus.c0_req = 1'b1; bus.c0_wr_en = wr; bus.c0_addr = addr; bus.c0_wdata = wdata;
    end else begin
      bus.c1_req = 1'b1; bus.c1_wr_en = wr; bus.c1_addr = addr; bus.c1_wdata = wdata;
    end
  endtask

  task automatic clear_reqs();
    bus.c0_req = 1'b0;
    bus.c1_req = 1'b0;
  endtask

  task automatic push_exp(input int port, input bit rd, input logic [63:0] addr,
                          input logic [63:0] rbase);
    exp_t x;
    x.port = port; x.rd = rd; x.addr = addr; x.line = mk_line(rbase);
    exp_q.push_back(x);
  endtask

  // Memory-side model: waits for m_req, grants after grant_delay cycles, then
  // sinks write beats or sources read beats (rbase+k), and records the completion.
  task automatic run_bus(input int grant_delay, input int gap_after, input logic [63:0] rbase,
                         input int dup_at, input int dup_port, input int abort_after);
    logic [ADDRESSSIZE-1:0] a0;
    logic                   w0;
    int                     n;
    obs_timeout = 0; obs_stable = 1; obs_early_wv = 0; obs_consec = 1;
    obs_nbeats = 0; obs_vport = -1; obs_vlat = -1; obs_vlen = 0; obs_reqlat = -1;
    n = 0;
    while (bus.m_req !== 1'b1 && n < 20) begin
      if (bus.m_wvalid === 1'b1) obs_early_wv = 1;
      tick();
      n++;
    end
    if (bus.m_req !== 1'b1) begin
      obs_timeout = 1;
      return;
    end
    obs_reqlat = n + 1;
    obs_addr = bus.m_addr; obs_wr = bus.m_wr; a0 = bus.m_addr; w0 = bus.m_wr;
    for (int i = 0; i < grant_delay; i++) begin
      if (bus.m_req !== 1'b1 || bus.m_addr !== a0 || bus.m_wr !== w0) obs_stable = 0;
      if (bus.m_wvalid === 1'b1) obs_early_wv = 1;
      tick();
    end
    if (bus.m_req !== 1'b1 || bus.m_addr !== a0) obs_stable = 0;
    if (bus.m_wvalid === 1'b1) obs_early_wv = 1;
    bus.m_grant = 1'b1;
    tick();
    bus.m_grant = 1'b0;
    if (w0 === 1'b1) begin
      n = 0;
      while (obs_nbeats < 8 && n < 20) begin
        if (bus.m_wvalid === 1'b1) begin
          obs_beats[obs_nbeats] = bus.m_wdata;
          obs_nbeats++;
        end else begin
          obs_consec = 0;
        end
        tick();
        n++;
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = rbase + 64'(k);
        if (k == dup_at) begin
          if (dup_port == 0) bus.c0_req = 1'b1;
          else bus.c1_req = 1'b1;
        end
        tick();
        clear_reqs();
        if (k == abort_after) begin
          bus.m_rvalid = 1'b0;
          #1 rst = 1'b0;
          #1;
          return;
        end
        if (k == gap_after) begin
          bus.m_rvalid = 1'b0;
          bus.m_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
          tick();
        end
      end
      bus.m_rvalid = 1'b0;
    end
    n = 0;
    while (!(bus.c0_valid === 1'b1 || bus.c1_valid === 1'b1) && n < 10) begin
      tick();
      n++;
    end
    if (bus.c0_valid === 1'b1 || bus.c1_valid === 1'b1) begin
      obs_vlat  = n + 1;
      obs_vport = (bus.c1_valid === 1'b1) ? 1 : 0;
      obs_rdata = (obs_vport == 1) ? bus.c1_rdata : bus.c0_rdata;
      obs_vlen  = 1;
      tick();
      if (bus.c0_valid === 1'b1 || bus.c1_valid === 1'b1) obs_vlen = 2;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.m_req, bus.m_wr, bus.m_wvalid, bus.c0_valid, bus.c1_valid} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000",
               {bus.m_req, bus.m_wr, bus.m_wvalid, bus.c0_valid, bus.c1_valid});
    end
    checks++;
    if (bus.m_addr !== '0 || bus.m_wdata !== '0) begin
      errors++;
      $display("[TB] FAIL reset_bus: got addr %h wdata %h expected 0", bus.m_addr, bus.m_wdata);
    end
    checks++;
    if (bus.c0_rdata !== '0 || bus.c1_rdata !== '0) begin
      errors++;
      $display("[TB] FAIL reset_rdata: got nonzero rdata expected 0");
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    set_req(0, 1'b0, 64'h1047, '0);
    push_exp(0, 1'b1, 64'h1040, 64'h0);
    tick();
    clear_reqs();
    run_bus(1, 3, 64'h0, -1, 0, -1);
    checks++;
    if (obs_reqlat !== 2) begin
      errors++; $display("[TB] FAIL rd_req_latency: got %0d expected 2", obs_reqlat);
    end
    checks++;
    if (obs_addr !== 64'h1040 || obs_wr !== 1'b0) begin
      errors++; $display("[TB] FAIL rd_addr: got %h wr %b expected 1040 wr 0", obs_addr, obs_wr);
    end
    checks++;
    if (obs_rdata[63:0] !== 64'h0 || obs_rdata[511:448] !== 64'h7) begin
      errors++;
      $display("[TB] FAIL rd_edge_beats: got %h / %h expected 0 / 7", obs_rdata[63:0], obs_rdata[511:448]);
    end
    checks++;
    if (obs_vport !== 0 || obs_vlat !== 1 || obs_vlen !== 1) begin
      errors++;
      $display("[TB] FAIL rd_valid: got port %0d lat %0d len %0d expected 0 1 1", obs_vport, obs_vlat, obs_vlen);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("[TB] FAIL rd_sb: got completion expected none queued");
    end else begin
      e = exp_q.pop_front();
      if (obs_rdata !== e.line) begin
        errors++; $display("[TB] FAIL rd_sb: got %h expected %h", obs_rdata, e.line);
      end
    end
  endtask

  task automatic test_single_write();
    int v0_before;
    v0_before = v0_total;
    set_req(1, 1'b1, 64'h2010, mk_line(64'hA0));
    push_exp(1, 1'b0, 64'h2000, 64'h0);
    tick();
    clear_reqs();
    run_bus(0, -1, 64'h0, -1, 0, -1);
    checks++;
    if (obs_wr !== 1'b1 || obs_addr !== 64'h2000) begin
      errors++; $display("[TB] FAIL wr_addr: got %h wr %b expected 2000 wr 1", obs_addr, obs_wr);
    end
    checks++;
    if (obs_nbeats !== 8 || obs_consec !== 1'b1) begin
      errors++; $display("[TB] FAIL wr_beats: got %0d consec %b expected 8 consec 1", obs_nbeats, obs_consec);
    end
    for (int k = 0; k < obs_nbeats; k++) begin
      checks++;
      if (obs_beats[k] !== 64'hA0 + 64'(k)) begin
        errors++; $display("[TB] FAIL wr_beat%0d: got %h expected %h", k, obs_beats[k], 64'hA0 + 64'(k));
      end
    end
    checks++;
    if (obs_vport !== 1 || obs_vlat !== 1 || obs_vlen !== 1) begin
      errors++;
      $display("[TB] FAIL wr_valid: got port %0d lat %0d len %0d expected 1 1 1", obs_vport, obs_vlat, obs_vlen);
    end
    checks++;
    if (v0_total !== v0_before) begin
      errors++; $display("[TB] FAIL wr_c0_quiet: got %0d c0 pulses expected 0", v0_total - v0_before);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_vport !== e.port) begin
        errors++; $display("[TB] FAIL wr_sb_port: got %0d expected %0d", obs_vport, e.port);
      end
    end
  endtask

  task automatic test_round_robin();
    int first;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
    first = 1;
`else
    first = 0;
`endif
    for (int p = 0; p < 2; p++) begin
      set_req(0, 1'b0, 64'h3000, '0);
      set_req(1, 1'b0, 64'h4000, '0);
      push_exp(first, 1'b1, (first == 0) ? 64'h3000 : 64'h4000, 64'h100 + 64'(p));
      push_exp(1 - first, 1'b1, (first == 0) ? 64'h4000 : 64'h3000, 64'h200 + 64'(p));
      tick();
      clear_reqs();
      for (int t = 0; t < 2; t++) begin
        run_bus(0, -1, ((t == 0) ? 64'h100 : 64'h200) + 64'(p), -1, 0, -1);
        if (t == 1) begin
          checks++;
          if (obs_reqlat !== 2) begin
            errors++; $display("[TB] FAIL b2b_gap: got %0d expected 2", obs_reqlat);
          end
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL rr_sb: got completion expected none queued");
        end else begin
          e = exp_q.pop_front();
          if (obs_vport !== e.port || obs_addr !== e.addr || obs_rdata !== e.line) begin
            errors++;
            $display("[TB] FAIL rr_order: pair %0d txn %0d got port %0d addr %h expected port %0d addr %h",
                     p, t, obs_vport, obs_addr, e.port, e.addr);
          end
        end
      end
    end
  endtask

  task automatic test_duplicate();
    int  v0_before;
    bit  extra_req;
    v0_before = v0_total;
    set_req(0, 1'b0, 64'h5000, '0);
    push_exp(0, 1'b1, 64'h5000, 64'h300);
    tick();
    clear_reqs();
    run_bus(0, -1, 64'h300, 2, 0, -1);
    extra_req = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.m_req === 1'b1) extra_req = 1;
      tick();
    end
    checks++;
    if (extra_req !== 1'b0) begin
      errors++; $display("[TB] FAIL dup_extra_txn: got m_req after completion expected none");
    end
    checks++;
    if (v0_total - v0_before !== 1) begin
      errors++; $display("[TB] FAIL dup_valid_count: got %0d expected 1", v0_total - v0_before);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("[TB] FAIL dup_sb: got completion expected none queued");
    end else begin
      e = exp_q.pop_front();
      if (obs_vport !== e.port || obs_rdata !== e.line) begin
        errors++; $display("[TB] FAIL dup_sb: got port %0d expected %0d", obs_vport, e.port);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int  v_before;
    bit  stray_req;
    set_req(0, 1'b0, 64'h6000, '0);
    tick();
    clear_reqs();
    run_bus(0, -1, 64'h400, 2, 1, 4);
    v_before = v0_total + v1_total;
    checks++;
    if ({bus.m_req, bus.m_wr, bus.m_wvalid, bus.c0_valid, bus.c1_valid} !== 5'b0 ||
        bus.m_addr !== '0 || bus.c0_rdata !== '0) begin
      errors++;
      $display("[TB] FAIL abort_outputs: got ctrl %b addr %h expected all 0",
               {bus.m_req, bus.m_wr, bus.m_wvalid, bus.c0_valid, bus.c1_valid}, bus.m_addr);
    end
    repeat (2) tick();
    rst = 1'b1;
    stray_req = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.m_req === 1'b1) stray_req = 1;
    end
    checks++;
    if (v0_total + v1_total !== v_before || stray_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_quiet: got %0d pulses req %b expected 0 pulses req 0",
               v0_total + v1_total - v_before, stray_req);
    end
    set_req(0, 1'b0, 64'h7000, '0);
    push_exp(0, 1'b1, 64'h7000, 64'h500);
    tick();
    clear_reqs();
    run_bus(0, -1, 64'h500, -1, 0, -1);
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("[TB] FAIL abort_rerun: got completion expected none queued");
    end else begin
      e = exp_q.pop_front();
      if (obs_vport !== e.port || obs_addr !== e.addr || obs_rdata !== e.line) begin
        errors++;
        $display("[TB] FAIL abort_rerun: got port %0d line[63:0] %h expected port %0d line[63:0] %h",
                 obs_vport, obs_rdata[63:0], e.port, e.line[63:0]);
      end
    end
  endtask

  task automatic test_grant_stall();
    set_req(1, 1'b1, 64'h8000, mk_line(64'hB0));
    push_exp(1, 1'b0, 64'h8000, 64'h0);
    tick();
    clear_reqs();
    run_bus(5, -1, 64'h0, -1, 0, -1);
    checks++;
    if (obs_timeout !== 1'b0 || obs_stable !== 1'b1 || obs_early_wv !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_hold: got timeout %b stable %b early_wvalid %b expected 0 1 0",
               obs_timeout, obs_stable, obs_early_wv);
    end
    checks++;
    if (obs_nbeats !== 8 || obs_beats[0] !== 64'hB0 || obs_beats[7] !== 64'hB7) begin
      errors++;
      $display("[TB] FAIL stall_beats: got %0d beats first %h last %h expected 8 b0 b7",
               obs_nbeats, obs_beats[0], obs_beats[7]);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("[TB] FAIL stall_sb: got completion expected none queued");
    end else begin
      e = exp_q.pop_front();
      if (obs_vport !== e.port || obs_addr !== e.addr) begin
        errors++; $display("[TB] FAIL stall_sb: got port %0d addr %h expected %0d %h",
                           obs_vport, obs_addr, e.port, e.addr);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.c0_req = 1'b0; bus.c1_req = 1'b0; bus.c0_wr_en = 1'b0; bus.c1_wr_en = 1'b0;
    bus.c0_addr = '0; bus.c1_addr = '0; bus.c0_wdata = '0; bus.c1_wdata = '0;
    bus.m_grant = 1'b0; bus.m_rdata = '0; bus.m_rvalid = 1'b0;
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_duplicate();
    test_reset_mid_read();
    test_grant_stall();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("[TB] FAIL sb_drain: got %0d left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
